// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding and the
// parameter range checks used at elaboration.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  localparam int BAUD_DIV_MIN  = 2;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  function automatic bit baud_div_ok(input int b);
    return b >= BAUD_DIV_MIN;
  endfunction

  function automatic bit data_bits_ok(input int d);
    return (d >= DATA_BITS_MIN) && (d <= DATA_BITS_MAX);
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer with a configurable reset / power-up value.
// Both flops start at RST_VAL so an idle-high line reads idle from time zero.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q = RST_VAL;
  logic sync_q = RST_VAL;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first data, stop-bit check with
// a one-shot framing error and a wait for the line to return high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = 3,
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF   = CW'((BAUD_DIV - 1) / 2);
  localparam logic [IW-1:0] LAST   = IW'(DATA_BITS - 1);

  if (!baud_div_ok(BAUD_DIV)) begin : g_bad_baud
    $error("uart_rx: BAUD_DIV must be >= 2");
  end
  if (!data_bits_ok(DATA_BITS)) begin : g_bad_bits
    $error("uart_rx: DATA_BITS must be in 5..9");
  end

  logic rx_s;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .d_i    (i_rx),
    .q_o    (rx_s)
  );

  rx_state_e            state_q = ST_IDLE;
  logic [CW-1:0]        cnt_q   = '0;
  logic [IW-1:0]        idx_q   = '0;
  logic [DATA_BITS-1:0] shift_q = '0;
  logic [DATA_BITS-1:0] data_q  = '0;
  logic                 valid_q = 1'b0;
  logic                 ferr_q  = 1'b0;
  logic                 tick;

  assign tick = (cnt_q == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (state_q != ST_IDLE) begin
        cnt_q <= tick ? RELOAD : cnt_q - 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_START;
            cnt_q   <= HALF;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_s) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_DATA;
              idx_q   <= '0;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == LAST) begin
              state_q <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (rx_s) begin
              valid_q <= 1'b1;
              data_q  <= shift_q;
              state_q <= ST_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_WAIT_HIGH;
            end
          end
        end
        // a held-low break must not retrigger until the line recovers
        ST_WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != ST_IDLE);

`ifdef FORMAL
  always_ff @(posedge i_clk) begin
    assert (!(valid_q && ferr_q));
  end
`endif

endmodule
